audio_frame_ctrl: RTL and testbench

Parametrised control and result unit for the audio engine, attached to the RISC-V iomem bus. Each frame it sequences an engine run: stretched engine reset, wait for done, then atomic swap of the double-buffered results. Engine runs are triggered by a sample strobe or a bus write. It generalises fixed stereo result capture to OUT_CHANS channels and adds a frame counter, timeout, sticky error/overrun status and an interrupt.

---
 rtl/audio_frame_ctrl_pkg.sv | 32 +++
 rtl/audio_frame_ctrl_if.sv | 25 ++
 rtl/audio_frame_ctrl_iomem_slave.sv | 46 ++++
 rtl/audio_frame_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_audio_frame_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/audio_frame_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : audio_frame_ctrl_pkg
//  Description : Register offsets, bit indices and FSM encoding shared by the
//                audio frame control unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package audio_frame_ctrl_pkg;

    localparam logic [8:0] c_off_control = 9'h000;
    localparam logic [8:0] c_off_status  = 9'h004;
    localparam logic [8:0] c_off_frame   = 9'h008;
    localparam logic [8:0] c_off_kick    = 9'h00C;
    localparam logic [8:0] c_off_result  = 9'h100;

    localparam int c_ctrl_auto_en = 0;
    localparam int c_ctrl_irq_en  = 1;

    localparam int c_st_done    = 0;
    localparam int c_st_error   = 1;
    localparam int c_st_overrun = 2;
    localparam int c_st_busy    = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RST  = 2'd1,
        ST_RUN  = 2'd2,
        ST_SWAP = 2'd3
    } fsm_state_t;

endpackage
`default_nettype wire

// File: rtl/audio_frame_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : audio_frame_ctrl_if
//  Description : RISC-V iomem bus bundle with master and slave views.
//  Revision    : 1.0 - initial release
// ============================================================================
interface audio_frame_ctrl_if;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;

    modport master (
        output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        input  iomem_ready, iomem_rdata
    );

    modport slave (
        input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        output iomem_ready, iomem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/audio_frame_ctrl_iomem_slave.sv
`default_nettype none
// ============================================================================
//  Module      : audio_frame_ctrl_iomem_slave
//  Description : iomem address match with a one-cycle ready pulse and
//                read/write strobes. SPAN must be a power of two.
//  Revision    : 1.0 - initial release
// ============================================================================
module audio_frame_ctrl_iomem_slave #(
    parameter logic [31:0] BASE = 32'h0300_6000,
    parameter int          SPAN = 512
) (
    input  wire logic                    ck,
    input  wire logic                    rst,
    input  wire logic                    valid,
    input  wire logic [3:0]              wstrb,
    input  wire logic [31:0]             addr,
    output logic                         ready,
    output logic                         re,
    output logic                         we,
    output logic [$clog2(SPAN)-1:0]      offset
);
    localparam int c_off_w = $clog2(SPAN);

    logic r_ready;
    logic w_sel;
    logic w_accept;

    assign w_sel    = (addr[31:c_off_w] == BASE[31:c_off_w]);
    assign w_accept = valid & w_sel & ~r_ready;

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            r_ready <= 1'b0;
        end else begin
            r_ready <= w_accept;
        end
    end

    // Master holds address/data through the ready cycle, so writes commit then.
    assign ready  = r_ready;
    assign re     = w_accept & ~|wstrb;
    assign we     = r_ready & |wstrb;
    assign offset = addr[c_off_w-1:0];

endmodule
`default_nettype wire

// File: rtl/audio_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : audio_frame_ctrl
//  Description : Per-frame audio engine sequencer with double-buffered
//                results, status/interrupt and an iomem register window.
//  Revision    : 1.0 - initial release
// ============================================================================
module audio_frame_ctrl
    import audio_frame_ctrl_pkg::*;
#(
    parameter logic [31:0] ADDR      = 32'h0300_6000,
    parameter int          OUT_CHANS = 2,
    parameter int          DATA_W    = 16,
    parameter int          FRAME_W   = 5,
    parameter int          RESET_LEN = 4,
    parameter int          TIMEOUT   = 1024
) (
    input  wire logic                ck,
    input  wire logic                rst,
    audio_frame_ctrl_if.slave        bus,
    input  wire logic                sample_strobe,
    output logic [FRAME_W-1:0]       frame,
    output logic                     engine_rst_n,
    input  wire logic                eng_done,
    input  wire logic                eng_error,
    input  wire logic                out_we,
    input  wire logic [5:0]          out_addr,
    input  wire logic [DATA_W-1:0]   out_audio,
    output logic                     irq
);
    localparam int c_cnt_max = (TIMEOUT > RESET_LEN) ? TIMEOUT : RESET_LEN;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
    localparam logic [c_cnt_w-1:0] c_rst_last = c_cnt_w'(RESET_LEN - 1);
    localparam logic [c_cnt_w-1:0] c_run_last = c_cnt_w'(TIMEOUT - 1);

    fsm_state_t           r_state, w_state_nxt;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [FRAME_W-1:0]   r_frame;
    logic                 r_eng_rst_n;
    logic                 r_auto_en, r_irq_en;
    logic                 r_done, r_error, r_overrun;
    logic                 r_irq;
    logic [31:0]          r_rdata;
    logic [DATA_W-1:0]    r_back  [OUT_CHANS];
    logic [DATA_W-1:0]    r_front [OUT_CHANS];

    logic                 w_ready, w_re, w_we;
    logic [8:0]           w_off;
    logic [31:0]          w_wdata;
    logic                 w_strobe_trig, w_kick, w_trig, w_start;
    logic                 w_timeout, w_busy;
    logic [DATA_W-1:0]    w_res;
    logic [1:0]           w_control;
    logic [3:0]           w_status;
    logic [31:0]          w_rd_mux;
    logic                 w_unused_ok;

    audio_frame_ctrl_iomem_slave #(
        .BASE (ADDR),
        .SPAN (512)
    ) u_iomem_slave (
        .ck     (ck),
        .rst    (rst),
        .valid  (bus.iomem_valid),
        .wstrb  (bus.iomem_wstrb),
        .addr   (bus.iomem_addr),
        .ready  (w_ready),
        .re     (w_re),
        .we     (w_we),
        .offset (w_off)
    );

    assign w_wdata     = bus.iomem_wdata;
    assign w_unused_ok = ^w_wdata[31:3];

    assign w_strobe_trig = sample_strobe & r_auto_en;
    assign w_kick        = w_we & (w_off == c_off_kick);
    assign w_trig        = w_strobe_trig | w_kick;
    assign w_start       = (r_state == ST_IDLE) & w_trig;
    assign w_busy        = (r_state != ST_IDLE);

    always_comb begin
        w_state_nxt = r_state;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: if (w_trig) w_state_nxt = ST_RST;
            ST_RST:  if (r_cnt == c_rst_last) w_state_nxt = ST_RUN;
            ST_RUN: begin
                // Completion wins over a timeout landing in the same cycle.
                if (eng_done) begin
                    w_state_nxt = ST_SWAP;
                end else if (r_cnt == c_run_last) begin
                    w_state_nxt = ST_IDLE;
                    w_timeout   = 1'b1;
                end
            end
            ST_SWAP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_eng_rst_n <= 1'b0;
            r_frame     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_eng_rst_n <= (w_state_nxt != ST_RST);
            if (r_state != w_state_nxt) begin
                r_cnt <= '0;
            end else if (r_state == ST_RST || r_state == ST_RUN) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_start && w_strobe_trig) begin
                r_frame <= r_frame + 1'b1;
            end
        end
    end

    // Clears from a STATUS write apply first so a coincident event is not lost.
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            r_auto_en <= 1'b0;
            r_irq_en  <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            r_overrun <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            if (w_we && w_off == c_off_control) begin
                r_auto_en <= w_wdata[c_ctrl_auto_en];
                r_irq_en  <= w_wdata[c_ctrl_irq_en];
            end
            if (w_we && w_off == c_off_status) begin
                r_done <= 1'b0;
                if (w_wdata[c_st_error])   r_error   <= 1'b0;
                if (w_wdata[c_st_overrun]) r_overrun <= 1'b0;
            end
            if (r_state == ST_SWAP)                         r_done    <= 1'b1;
            if ((r_state == ST_RUN && eng_error) || w_timeout) r_error <= 1'b1;
            if (w_trig && r_state != ST_IDLE)               r_overrun <= 1'b1;
            r_irq <= r_irq_en & (r_done | r_error | r_overrun);
        end
    end

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            for (int n = 0; n < OUT_CHANS; n++) begin
                r_back[n]  <= '0;
                r_front[n] <= '0;
            end
        end else begin
            if (w_start) begin
                for (int n = 0; n < OUT_CHANS; n++) r_back[n] <= '0;
            end else if (r_state == ST_RUN && out_we) begin
                for (int n = 0; n < OUT_CHANS; n++) begin
                    if (out_addr == 6'(n)) r_back[n] <= out_audio;
                end
            end
            if (r_state == ST_SWAP) begin
                for (int n = 0; n < OUT_CHANS; n++) r_front[n] <= r_back[n];
            end
        end
    end

    always_comb begin
        w_res = '0;
        for (int n = 0; n < OUT_CHANS; n++) begin
            if (w_off[7:2] == 6'(n)) w_res = r_front[n];
        end
        w_control                 = '0;
        w_control[c_ctrl_auto_en] = r_auto_en;
        w_control[c_ctrl_irq_en]  = r_irq_en;
        w_status                  = '0;
        w_status[c_st_done]       = r_done;
        w_status[c_st_error]      = r_error;
        w_status[c_st_overrun]    = r_overrun;
        w_status[c_st_busy]       = w_busy;
        w_rd_mux = '0;
        case (w_off)
            c_off_control: w_rd_mux = {30'd0, w_control};
            c_off_status:  w_rd_mux = {28'd0, w_status};
            c_off_frame:   w_rd_mux = 32'(r_frame);
            default: begin
                if (w_off >= c_off_result) w_rd_mux = 32'($signed(w_res));
            end
        endcase
    end

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= w_re ? w_rd_mux : '0;
        end
    end

    assign bus.iomem_ready = w_ready;
    assign bus.iomem_rdata = r_rdata;
    assign frame           = r_frame;
    assign engine_rst_n    = r_eng_rst_n;
    assign irq             = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_audio_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_audio_frame_ctrl
//  Description : Self-checking bench for audio_frame_ctrl with a timing-level
//                reference model and directed scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_frame_ctrl;
    localparam logic [31:0] ADDR = 32'h0300_6000;
    localparam int OUT = 2;
    localparam int DW  = 16;
    localparam int FW  = 5;
    localparam int RL  = 4;
    localparam int TO  = 1024;

    localparam logic [31:0] A_CTRL = ADDR + 32'h000;
    localparam logic [31:0] A_STAT = ADDR + 32'h004;
    localparam logic [31:0] A_FRM  = ADDR + 32'h008;
    localparam logic [31:0] A_KICK = ADDR + 32'h00C;
    localparam logic [31:0] A_RES0 = ADDR + 32'h100;
    localparam logic [31:0] A_RES1 = ADDR + 32'h104;
    localparam logic [31:0] A_RES5 = ADDR + 32'h114;

    logic          ck = 1'b0;
    logic          rst_n = 1'b0;
    logic          sample_strobe = 1'b0;
    logic [FW-1:0] frame;
    logic          engine_rst_n;
    logic          eng_done = 1'b0;
    logic          eng_error = 1'b0;
    logic          out_we = 1'b0;
    logic [5:0]    out_addr = '0;
    logic [DW-1:0] out_audio = '0;
    logic          irq;

    audio_frame_ctrl_if bus();

    audio_frame_ctrl #(
        .ADDR(ADDR), .OUT_CHANS(OUT), .DATA_W(DW), .FRAME_W(FW),
        .RESET_LEN(RL), .TIMEOUT(TO)
    ) dut (
        .ck(ck), .rst(rst_n), .bus(bus), .sample_strobe(sample_strobe),
        .frame(frame), .engine_rst_n(engine_rst_n), .eng_done(eng_done),
        .eng_error(eng_error), .out_we(out_we), .out_addr(out_addr),
        .out_audio(out_audio), .irq(irq)
    );

    always #5 ck = ~ck;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (cycle-index arithmetic) ----------------
    int            cyc, m_start;
    bit            m_busy, m_swap, m_done, m_err, m_ovr, m_ready, m_irq, m_eng;
    logic [1:0]    m_ctrl;
    logic [FW-1:0] m_frame;
    logic [DW-1:0] m_front [OUT];
    logic [DW-1:0] m_back  [OUT];
    logic [31:0]   m_rdata;

    function automatic logic [31:0] model_read(input logic [8:0] off);
        int idx;
        if (off == 9'h000) return {30'd0, m_ctrl};
        if (off == 9'h004) return {28'd0, m_busy, m_ovr, m_err, m_done};
        if (off == 9'h008) return {27'd0, m_frame};
        if (off >= 9'h100) begin
            idx = (int'(off) - 256) / 4;
            if (idx < OUT) return {{16{m_front[idx][DW-1]}}, m_front[idx]};
        end
        return 32'd0;
    endfunction

    always @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            cyc = 0; m_start = -100; m_busy = 0; m_swap = 0; m_done = 0; m_err = 0;
            m_ovr = 0; m_ready = 0; m_irq = 0; m_eng = 0; m_ctrl = 0; m_frame = 0;
            m_rdata = 0;
            for (int i = 0; i < OUT; i++) begin m_front[i] = 0; m_back[i] = 0; end
        end else begin
            int k;
            bit in_run, in_swap, was_idle, acc, wr, strobe_t, kick;
            logic [8:0] off;
            cyc++;
            k        = cyc - m_start;
            in_swap  = m_swap;
            in_run   = m_busy && !m_swap && (k > RL);
            was_idle = !m_busy;
            off      = bus.iomem_addr[8:0];
            acc      = bus.iomem_valid && (bus.iomem_addr[31:9] == ADDR[31:9]) && !m_ready;
            wr       = m_ready && (bus.iomem_wstrb != 0);
            m_irq    = m_ctrl[1] && (m_done || m_err || m_ovr);
            m_rdata  = (acc && bus.iomem_wstrb == 0) ? model_read(off) : 32'd0;
            m_ready  = acc;
            kick     = wr && off == 9'h00C;
            strobe_t = sample_strobe && m_ctrl[0];
            if (wr && off == 9'h004) begin
                m_done = 0;
                if (bus.iomem_wdata[1]) m_err = 0;
                if (bus.iomem_wdata[2]) m_ovr = 0;
            end
            if (wr && off == 9'h000) m_ctrl = bus.iomem_wdata[1:0];
            if (in_run) begin
                if (out_we && out_addr < OUT) m_back[out_addr] = out_audio;
                if (eng_error) m_err = 1;
                if (eng_done) m_swap = 1;
                else if (k - RL == TO) begin m_busy = 0; m_err = 1; end
            end
            if (in_swap) begin
                for (int i = 0; i < OUT; i++) m_front[i] = m_back[i];
                m_done = 1; m_swap = 0; m_busy = 0;
            end
            if (kick || strobe_t) begin
                if (was_idle) begin
                    m_busy = 1; m_start = cyc;
                    for (int i = 0; i < OUT; i++) m_back[i] = 0;
                    if (strobe_t) m_frame = m_frame + 1'b1;
                end else begin
                    m_ovr = 1;
                end
            end
            m_eng = !(m_busy && !m_swap && (cyc + 1 - m_start) <= RL);
        end
    end

    always @(negedge ck) begin
        if (rst_n) begin
            check("cyc_engine_rst_n", engine_rst_n, m_eng);
            check("cyc_frame", frame, m_frame);
            check("cyc_irq", irq, m_irq);
            check("cyc_ready", bus.iomem_ready, m_ready);
            check("cyc_rdata", bus.iomem_rdata, m_rdata);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic bus_xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input bit strobe_on_ready, output logic [31:0] rd);
        bit got = 0;
        @(negedge ck);
        bus.iomem_valid = 1; bus.iomem_addr = a; bus.iomem_wdata = d; bus.iomem_wstrb = s;
        for (int i = 0; i < 8; i++) begin
            @(negedge ck);
            if (bus.iomem_ready) begin got = 1; break; end
        end
        rd = bus.iomem_rdata;
        if (strobe_on_ready) sample_strobe = 1;
        @(negedge ck);
        sample_strobe = 0;
        bus.iomem_valid = 0; bus.iomem_wstrb = 0; bus.iomem_addr = 0; bus.iomem_wdata = 0;
        check("bus_ready_seen", {31'd0, got}, 32'd1);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        bus_xfer(a, d, 4'hF, 1'b0, dummy);
    endtask

    task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] v;
        bus_xfer(a, 32'd0, 4'h0, 1'b0, v);
        check(name, v, exp);
    endtask

    task automatic pulse_strobe();
        @(negedge ck); sample_strobe = 1;
        @(negedge ck); sample_strobe = 0;
    endtask

    task automatic out_write(input logic [5:0] a, input logic [DW-1:0] d, input bit done);
        @(negedge ck); out_we = 1; out_addr = a; out_audio = d; eng_done = done;
        @(negedge ck); out_we = 0; eng_done = 0;
    endtask

    task automatic finish_run();
        @(negedge ck); eng_done = 1;
        @(negedge ck); eng_done = 0;
        repeat (3) @(negedge ck);
    endtask

    initial begin
        int lows;
        bus.iomem_valid = 0; bus.iomem_wstrb = 0; bus.iomem_addr = 0; bus.iomem_wdata = 0;

        repeat (3) @(negedge ck);
        check("rst_engine_low", engine_rst_n, 32'd0);
        check("rst_frame", frame, 32'd0);
        check("rst_irq", irq, 32'd0);
        check("rst_rdata", bus.iomem_rdata, 32'd0);
        #2 rst_n = 1;
        repeat (2) @(negedge ck);
        check("post_rst_engine_high", engine_rst_n, 32'd1);

        rd("rst_status", A_STAT, 32'h0);
        rd("rst_frame_reg", A_FRM, 32'h0);
        rd("rst_result0", A_RES0, 32'h0);

        // First strobe-triggered run
        wr(A_CTRL, 32'h1);
        pulse_strobe();
        lows = 0;
        for (int i = 0; i < 12; i++) begin
            if (!engine_rst_n) lows++;
            @(negedge ck);
        end
        check("reset_len_cycles", lows, RL);
        check("frame_after_strobe", frame, 32'd1);
        out_write(6'd0, 16'h8001, 1'b0);
        out_write(6'd1, 16'h1234, 1'b1);
        repeat (3) @(negedge ck);
        rd("result0_neg", A_RES0, 32'hFFFF_8001);
        rd("result1_pos", A_RES1, 32'h0000_1234);
        rd("status_done", A_STAT, 32'h1);

        // Overrun on a strobe during RUN
        pulse_strobe();
        repeat (RL + 1) @(negedge ck);
        pulse_strobe();
        check("frame_no_inc_overrun", frame, 32'd2);
        rd("status_overrun_busy", A_STAT, 32'hD);
        wr(A_STAT, 32'h4);
        rd("status_overrun_cleared", A_STAT, 32'h8);
        out_write(6'd0, 16'h0042, 1'b0);
        out_write(6'd1, 16'h7FFF, 1'b1);
        repeat (3) @(negedge ck);
        rd("status_done2", A_STAT, 32'h1);
        rd("result0_run2", A_RES0, 32'h0000_0042);
        rd("result1_run2", A_RES1, 32'h0000_7FFF);

        // Timeout: no eng_done
        wr(A_STAT, 32'h7);
        pulse_strobe();
        repeat (RL + 1) @(negedge ck);
        out_write(6'd0, 16'h1111, 1'b0);
        repeat (TO + 5) @(negedge ck);
        rd("status_timeout", A_STAT, 32'h2);
        rd("result0_after_timeout", A_RES0, 32'h0000_0042);
        rd("result1_after_timeout", A_RES1, 32'h0000_7FFF);

        // Interrupt and out-of-range capture
        wr(A_STAT, 32'h7);
        wr(A_CTRL, 32'h3);
        check("irq_idle_low", irq, 32'd0);
        pulse_strobe();
        repeat (RL + 1) @(negedge ck);
        out_write(6'd5, 16'h5555, 1'b0);
        out_write(6'd0, 16'hABCD, 1'b0);
        @(negedge ck); eng_done = 1;
        @(negedge ck); eng_done = 0;
        @(negedge ck);
        check("irq_not_yet", irq, 32'd0);
        @(negedge ck);
        check("irq_after_swap", irq, 32'd1);
        rd("result0_run4", A_RES0, 32'hFFFF_ABCD);
        rd("result1_cleared", A_RES1, 32'h0);
        rd("result5_oob", A_RES5, 32'h0);
        wr(A_STAT, 32'h0);
        @(negedge ck);
        check("irq_cleared", irq, 32'd0);
        check("frame_four", frame, 32'd4);

        // Frame wrap
        wr(A_CTRL, 32'h1);
        for (int r = 0; r < 27; r++) begin
            pulse_strobe();
            repeat (RL + 3) @(negedge ck);
            finish_run();
        end
        check("frame_31", frame, 32'd31);
        rd("frame_reg_31", A_FRM, 32'd31);
        pulse_strobe();
        repeat (RL + 3) @(negedge ck);
        finish_run();
        check("frame_wrap_0", frame, 32'd0);

        // KICK with auto disabled
        wr(A_CTRL, 32'h0);
        wr(A_STAT, 32'h7);
        pulse_strobe();
        repeat (3) @(negedge ck);
        check("strobe_ignored", engine_rst_n, 32'd1);
        wr(A_KICK, 32'h0);
        check("kick_starts_reset", engine_rst_n, 32'd0);
        check("kick_frame_same", frame, 32'd0);
        repeat (RL + 1) @(negedge ck);
        finish_run();
        rd("kick_status_done", A_STAT, 32'h1);
        rd("kick_reads_zero", A_KICK, 32'h0);

        // Simultaneous strobe and KICK
        wr(A_CTRL, 32'h1);
        wr(A_STAT, 32'h7);
        begin
            logic [31:0] dummy;
            bus_xfer(A_KICK, 32'h0, 4'hF, 1'b1, dummy);
        end
        check("dual_trigger_frame", frame, 32'd1);
        repeat (RL + 1) @(negedge ck);
        finish_run();
        rd("dual_trigger_status", A_STAT, 32'h1);

        // Asynchronous reset mid-run
        pulse_strobe();
        repeat (RL + 3) @(negedge ck);
        #2 rst_n = 0;
        #1;
        check("async_engine_low", engine_rst_n, 32'd0);
        check("async_frame", frame, 32'd0);
        check("async_irq", irq, 32'd0);
        repeat (2) @(negedge ck);
        #2 rst_n = 1;
        rd("async_status", A_STAT, 32'h0);
        rd("async_result0", A_RES0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
